cam_config_seq: RTL and testbench

- Reader side of the OV7670 register-table ROM (`cam_rom`: 8-bit address, 16-bit `{reg_addr, reg_value}` words, 1-cycle synchronous read).
- Walks the table from address 0 and issues one SCCB register write per entry to the downstream SCCB master, using a start/ready handshake.
- Honours the in-table markers: `FF_F0` = settle delay, `FF_FF` = end of table.
- Sits between the top-level camera bring-up logic and the SCCB transmitter; runs once per start request.

---
 rtl/cam_config_seq_if.sv | 61 ++++++
 rtl/cam_config_seq.sv | 187 ++++++++++++++++++
 tb/tb_cam_config_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cam_config_seq_if.sv
// ---------------------------------------------------------------------------
// cam_config_seq_if
//
// Groups the signals between the camera configuration sequencer and its
// surroundings: the start/status handshake with the bring-up logic, the
// register-table ROM read port and the SCCB master write-request handshake.
//
// Signals (direction as seen by the sequencer, modport master):
//   i_start       in   single-cycle request to run the table from entry 0
//   o_rom_addr    out  ROM read address (ADDR_W bits)
//   i_rom_data    in   ROM word {reg_addr, reg_value}, valid one cycle later
//   o_sccb_start  out  single-cycle write request to the SCCB master
//   o_sccb_reg    out  register address for the write
//   o_sccb_val    out  register value for the write
//   i_sccb_ready  in   SCCB master idle / able to accept a request
//   o_busy        out  sequence in progress
//   o_done        out  end marker reached, held until next start
//   o_err         out  table overran without an end marker, held until next start
//
// The slave modport is the environment side (bring-up logic, ROM, SCCB).
// ---------------------------------------------------------------------------
interface cam_config_seq_if #(
    parameter int ADDR_W = 8
);
    logic              i_start;
    logic [ADDR_W-1:0] o_rom_addr;
    logic [15:0]       i_rom_data;
    logic              o_sccb_start;
    logic [7:0]        o_sccb_reg;
    logic [7:0]        o_sccb_val;
    logic              i_sccb_ready;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport master (
        input  i_start,
        input  i_rom_data,
        input  i_sccb_ready,
        output o_rom_addr,
        output o_sccb_start,
        output o_sccb_reg,
        output o_sccb_val,
        output o_busy,
        output o_done,
        output o_err
    );

    modport slave (
        output i_start,
        output i_rom_data,
        output i_sccb_ready,
        input  o_rom_addr,
        input  o_sccb_start,
        input  o_sccb_reg,
        input  o_sccb_val,
        input  o_busy,
        input  o_done,
        input  o_err
    );
endinterface

// File: rtl/cam_config_seq.sv
// ---------------------------------------------------------------------------
// cam_config_seq
//
// Reads the OV7670 register table from a 1-cycle-latency ROM, starting at
// entry 0, and hands each {reg_addr, reg_value} word to the SCCB master as a
// single write request. Two marker words are recognised:
//   16'hFFF0  settle delay of DELAY_CYCLES clocks, then continue
//   16'hFFFF  end of table, raise o_done
// Running off the last ROM entry without an end marker raises o_err; the
// index never wraps back to 0.
//
// Ports:
//   i_clk   system clock
//   i_rstn  asynchronous active-low reset
//   bus     cam_config_seq_if.master (start/status, ROM port, SCCB handshake)
//
// Parameters:
//   DELAY_CYCLES  clocks spent on a delay marker (minimum 1)
//   ADDR_W        ROM address width, table depth 2^ADDR_W
// ---------------------------------------------------------------------------
module cam_config_seq #(
    parameter int DELAY_CYCLES = 270000,
    parameter int ADDR_W       = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    cam_config_seq_if.master      bus
);

    // Counter only ever holds DELAY_CYCLES-1 down to 0.
    localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [15:0]       WORD_END = 16'hFFFF;
    localparam logic [15:0]       WORD_DLY = 16'hFFF0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_HOLD,
        S_WAIT,
        S_DELAY,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [7:0]        reg_q,   reg_d;
    logic [7:0]        val_q,   val_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;
    logic              start_c;
    logic              advance_c;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            reg_q   <= '0;
            val_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        reg_d     = reg_q;
        val_d     = val_q;
        done_d    = done_q;
        err_d     = err_q;
        start_c   = 1'b0;
        advance_c = 1'b0;

        case (state_q)
            S_IDLE, S_FIN: begin
                if (bus.i_start) begin
                    idx_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end

            // Address is already on o_rom_addr; the word arrives next cycle.
            S_FETCH: begin
                state_d = S_DECODE;
            end

            S_DECODE: begin
                if (bus.i_rom_data == WORD_END) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else if (bus.i_rom_data == WORD_DLY) begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_DELAY;
                end else begin
                    reg_d   = bus.i_rom_data[15:8];
                    val_d   = bus.i_rom_data[7:0];
                    state_d = S_SEND;
                end
            end

            // The request is combinational on ready so it can never be
            // raised while the master is busy, and it lasts one cycle
            // because the state leaves SEND on the same edge.
            S_SEND: begin
                if (bus.i_sccb_ready) begin
                    start_c = 1'b1;
                    state_d = S_HOLD;
                end
            end

            // Master may still show ready in the cycle after the request;
            // skip it so that stale ready is not taken as completion.
            S_HOLD: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (bus.i_sccb_ready) begin
                    advance_c = 1'b1;
                end
            end

            // Loaded with DELAY_CYCLES-1, so counting down through 0 gives
            // a dwell of exactly DELAY_CYCLES cycles.
            S_DELAY: begin
                if (cnt_q == '0) begin
                    advance_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Moving past the last entry is an overrun, not a wrap.
        if (advance_c) begin
            if (idx_q == LAST_IDX) begin
                err_d   = 1'b1;
                done_d  = 1'b0;
                state_d = S_FIN;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_FETCH;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. busy and start derive from the state register so both fall
    // as soon as reset asserts.
    // -----------------------------------------------------------------------
    assign bus.o_rom_addr   = idx_q;
    assign bus.o_sccb_start = start_c;
    assign bus.o_sccb_reg   = reg_q;
    assign bus.o_sccb_val   = val_q;
    assign bus.o_busy       = (state_q != S_IDLE) && (state_q != S_FIN);
    assign bus.o_done       = done_q;
    assign bus.o_err        = err_q;

endmodule

// File: tb/tb_cam_config_seq.sv
module tb_cam_config_seq;
    localparam int ADDR_W    = 8;
    localparam int DELAY     = 20;
    localparam int SCCB_BUSY = 50;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    cam_config_seq_if #(.ADDR_W(ADDR_W)) io ();

    cam_config_seq #(
        .DELAY_CYCLES(DELAY),
        .ADDR_W      (ADDR_W)
    ) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (io)
    );

    // ROM model: 1-cycle synchronous read
    logic [15:0] rom [0:255];
    always @(posedge clk) io.i_rom_data <= rom[io.o_rom_addr];

    // SCCB model: ready low for SCCB_BUSY cycles after each start
    int   busy_cnt = 0;
    logic hold_low = 1'b0;
    always @(posedge clk) begin
        if (io.o_sccb_start)     busy_cnt <= SCCB_BUSY;
        else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
    end
    assign io.i_sccb_ready = (busy_cnt == 0) && !hold_low;

    // Monitor, sampling on the falling edge
    logic [15:0] starts_q [$];
    int addr1_cyc = 0;
    int hs_viol   = 0;
    int wrap_viol = 0;
    bit prev_start = 1'b0;
    bit left_zero  = 1'b0;
    always @(negedge clk) begin
        if (io.o_sccb_start) begin
            starts_q.push_back({io.o_sccb_reg, io.o_sccb_val});
            if (!io.i_sccb_ready || prev_start) hs_viol++;
        end
        prev_start = io.o_sccb_start;
        if (io.o_busy && io.o_rom_addr == 8'd1) addr1_cyc++;
        if (io.i_start)                              left_zero = 1'b0;
        else if (io.o_busy && io.o_rom_addr != 8'd0) left_zero = 1'b1;
        else if (io.o_busy && left_zero)             wrap_viol++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive point is #1 after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        io.i_start = 1'b1;
        tick(1);
        io.i_start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!(io.o_done || io.o_err) && n < budget) begin
            tick(1);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic load_base();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1204;
        rom[3] = 16'h1100;
        rom[4] = 16'hFFFF;
    endtask

    task automatic chk_seq(input string tag, input int base);
        chk({tag, "_nstarts"}, 32'(starts_q.size() - base), 32'd3);
        if (starts_q.size() - base == 3) begin
            chk({tag, "_w0"}, 32'(starts_q[base]),     32'h1280);
            chk({tag, "_w1"}, 32'(starts_q[base + 1]), 32'h1204);
            chk({tag, "_w2"}, 32'(starts_q[base + 2]), 32'h1100);
        end
        chk({tag, "_done"}, 32'(io.o_done), 32'd1);
        chk({tag, "_busy"}, 32'(io.o_busy), 32'd0);
        chk({tag, "_err"},  32'(io.o_err),  32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  32'(io.o_busy),       32'd0);
        chk({tag, "_start"}, 32'(io.o_sccb_start), 32'd0);
        chk({tag, "_done"},  32'(io.o_done),       32'd0);
        chk({tag, "_err"},   32'(io.o_err),        32'd0);
        chk({tag, "_addr"},  32'(io.o_rom_addr),   32'd0);
        chk({tag, "_reg"},   32'(io.o_sccb_reg),   32'd0);
        chk({tag, "_val"},   32'(io.o_sccb_val),   32'd0);
    endtask

    initial begin
        int base;
        int a1;
        int n;
        int sv;
        int rv;

        rstn       = 1'b0;
        io.i_start = 1'b0;
        load_base();
        #1;
        chk_zero("reset");
        tick(3);
        rstn = 1'b1;
        tick(2);

        // End marker at entry 0: done two cycles after start, no writes
        rom[0] = 16'hFFFF;
        base = starts_q.size();
        pulse_start();
        tick(1);
        chk("empty_done_early", 32'(io.o_done), 32'd0);
        tick(1);
        chk("empty_done", 32'(io.o_done), 32'd1);
        chk("empty_busy", 32'(io.o_busy), 32'd0);
        chk("empty_nstarts", 32'(starts_q.size() - base), 32'd0);

        // Base sequence with delay measurement
        load_base();
        base = starts_q.size();
        a1   = addr1_cyc;
        pulse_start();
        wait_end("base", 2000);
        chk_seq("base", base);
        chk("base_addr1_cycles", 32'(addr1_cyc - a1), 32'(DELAY + 2));

        // Ready held low before the first write
        base = starts_q.size();
        hold_low = 1'b1;
        pulse_start();
        tick(3);
        sv = 0;
        rv = 0;
        for (int i = 0; i < 100; i++) begin
            if (io.o_sccb_start) sv++;
            if ({io.o_sccb_reg, io.o_sccb_val} != 16'h1280) rv++;
            tick(1);
        end
        chk("hold_no_start", 32'(sv), 32'd0);
        chk("hold_regval",   32'(rv), 32'd0);
        hold_low = 1'b0;
        #1;
        chk("hold_start_on_rise", 32'(io.o_sccb_start), 32'd1);
        wait_end("hold", 2000);
        chk_seq("hold", base);

        // Reset during the delay after entry 1
        pulse_start();
        n = 0;
        while (io.o_rom_addr != 8'd1 && n < 500) begin
            tick(1);
            n++;
        end
        chk("rst_reach_addr1", 32'(n < 500), 32'd1);
        tick(5);
        rstn = 1'b0;
        #1;
        chk_zero("rst_mid");
        tick(3);
        rstn = 1'b1;
        tick(1);
        base = starts_q.size();
        pulse_start();
        n = 0;
        while (starts_q.size() == base && n < 500) begin
            tick(1);
            n++;
        end
        chk("rst_restart_seen", 32'(starts_q.size() > base), 32'd1);
        if (starts_q.size() > base) chk("rst_restart_w0", 32'(starts_q[base]), 32'h1280);
        wait_end("rst_restart", 2000);
        chk_seq("rst_restart", base);

        // Start while busy is ignored; start in FIN reruns
        base = starts_q.size();
        pulse_start();
        tick(10);
        pulse_start();
        tick(40);
        pulse_start();
        wait_end("busy_start", 2000);
        chk_seq("busy_start", base);
        base = starts_q.size();
        io.i_start = 1'b1;
        tick(1);
        io.i_start = 1'b0;
        chk("fin_start_done_clr", 32'(io.o_done), 32'd0);
        chk("fin_start_busy",     32'(io.o_busy), 32'd1);
        wait_end("rerun", 2000);
        chk_seq("rerun", base);

        // Table without end marker: overrun
        for (int i = 0; i < 256; i++) rom[i] = 16'h1280;
        base = starts_q.size();
        pulse_start();
        wait_end("ovr", 30000);
        chk("ovr_nstarts", 32'(starts_q.size() - base), 32'd256);
        rv = 0;
        for (int i = base; i < starts_q.size(); i++)
            if (starts_q[i] != 16'h1280) rv++;
        chk("ovr_words", 32'(rv), 32'd0);
        chk("ovr_err",  32'(io.o_err),      32'd1);
        chk("ovr_done", 32'(io.o_done),     32'd0);
        chk("ovr_busy", 32'(io.o_busy),     32'd0);
        chk("ovr_addr", 32'(io.o_rom_addr), 32'hFF);
        chk("ovr_no_wrap", 32'(wrap_viol),  32'd0);

        chk("handshake_rules", 32'(hs_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
